// File: rtl/biu_constants_pkg.sv
// biu_constants_pkg: shared BIU transfer types plus the arbiter owner encoding.
package biu_constants_pkg;
  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  typedef logic [2:0] biu_prot_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_DM   = 2'b10
  } arb_owner_t;
endpackage

// File: rtl/riscv_biu_arb_cnt.sv
// riscv_biu_arb_cnt: saturating up/down counter of accepted-but-unanswered BIU transfers.
module riscv_biu_arb_cnt #(
  parameter int MAX_PEND = 2,
  parameter int CW       = $clog2(MAX_PEND) + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic full,
  output logic zero,
  output logic nxt_zero
);
  logic [CW-1:0] cnt, cnt_nxt;
  logic up, dn;
  assign up       = inc & ~dec & ~full;
  assign dn       = dec & ~inc & ~zero;
  assign cnt_nxt  = clr ? '0 : up ? cnt + CW'(1) : dn ? cnt - CW'(1) : cnt;
  assign full     = cnt >= CW'(MAX_PEND);
  assign zero     = cnt == '0;
  assign nxt_zero = cnt_nxt == '0;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter: shares one BIU request port between IF and DM requesters.
// Define RISCV_BIU_ARB_RR_EN for round-robin tie-breaking instead of fixed DM priority.
module riscv_biu_arbiter
  import biu_constants_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_PEND = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  input  biu_size_t       if_size_i,
  input  logic            if_lock_i,
  input  biu_prot_t       if_prot_i,
  input  logic            if_we_i,
  input  logic [XLEN-1:0] if_d_i,
  output logic            if_ack_o,
  output logic            if_d_ack_o,
  output logic [XLEN-1:0] if_q_o,
  input  logic            dm_req_i,
  input  logic [XLEN-1:0] dm_adr_i,
  input  biu_size_t       dm_size_i,
  input  logic            dm_lock_i,
  input  biu_prot_t       dm_prot_i,
  input  logic            dm_we_i,
  input  logic [XLEN-1:0] dm_d_i,
  output logic            dm_ack_o,
  output logic            dm_d_ack_o,
  output logic [XLEN-1:0] dm_q_o,
  output logic            biu_req_o,
  output logic [XLEN-1:0] biu_adr_o,
  output biu_size_t       biu_size_o,
  output logic            biu_lock_o,
  output biu_prot_t       biu_prot_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic            biu_ack_i,
  input  logic            biu_d_ack_i,
  input  logic [XLEN-1:0] biu_q_i,
  output arb_owner_t      owner_o
);
  arb_owner_t state, sel, idle_sel, tie_sel, last_grant;
  logic grant_if, grant_dm, sel_req, accept, lock_q, lock_nxt, rel;
  logic full, zero, nxt_zero, own_req, oth_req;
`ifdef RISCV_BIU_ARB_RR_EN
  assign tie_sel = last_grant == ARB_IF ? ARB_DM : ARB_IF;
`else
  logic last_grant_unused;
  assign last_grant_unused = ^last_grant;
  assign tie_sel = ARB_DM;
`endif
  assign idle_sel = if_req_i & dm_req_i ? tie_sel : dm_req_i ? ARB_DM : if_req_i ? ARB_IF : ARB_IDLE;
  assign sel      = state == ARB_IDLE ? idle_sel : state;
  assign grant_if = sel == ARB_IF;
  assign grant_dm = sel == ARB_DM;
  assign sel_req  = grant_dm ? dm_req_i : grant_if & if_req_i;
  assign biu_req_o  = sel_req & ~full & ~flush_i & ~rst_i;
  assign biu_adr_o  = grant_dm ? dm_adr_i  : if_adr_i;
  assign biu_size_o = grant_dm ? dm_size_i : if_size_i;
  assign biu_lock_o = grant_dm ? dm_lock_i : if_lock_i;
  assign biu_prot_o = grant_dm ? dm_prot_i : if_prot_i;
  assign biu_we_o   = grant_dm ? dm_we_i   : if_we_i;
  assign biu_d_o    = grant_dm ? dm_d_i    : if_d_i;
  assign accept     = biu_req_o & biu_ack_i;
  assign if_ack_o   = accept & grant_if;
  assign dm_ack_o   = accept & grant_dm;
  assign if_d_ack_o = biu_d_ack_i & (state == ARB_IF);
  assign dm_d_ack_o = biu_d_ack_i & (state == ARB_DM);
  assign if_q_o     = biu_q_i;
  assign dm_q_o     = biu_q_i;
  assign owner_o    = state;
  assign lock_nxt = ~flush_i & (accept ? biu_lock_o : lock_q);
  assign own_req  = state == ARB_DM ? dm_req_i : if_req_i;
  assign oth_req  = state == ARB_DM ? if_req_i : dm_req_i;
  // a waiting peer forces release even if the owner keeps requesting
  assign rel      = nxt_zero & ~lock_nxt & (~own_req | oth_req);

  riscv_biu_arb_cnt #(.MAX_PEND(MAX_PEND)) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (accept),
    .dec      (biu_d_ack_i & ~zero),
    .clr      (1'b0),
    .full     (full),
    .zero     (zero),
    .nxt_zero (nxt_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state      <= ARB_IDLE;
      lock_q     <= 1'b0;
      last_grant <= ARB_IF;
    end else begin
      lock_q <= lock_nxt;
      if (state == ARB_IDLE && accept) begin
        state      <= sel;
        last_grant <= sel;
      end else if (state != ARB_IDLE && rel) state <= ARB_IDLE;
    end
endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// tb_riscv_biu_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_riscv_biu_arbiter;
  import biu_constants_pkg::*;
  localparam int XLEN = 32;
  localparam int MAXP = 2;

  logic clk = 1'b0, rst, flush;
  logic if_req, if_lock, if_we, dm_req, dm_lock, dm_we;
  logic [XLEN-1:0] if_adr, if_d, dm_adr, dm_d, if_q, dm_q;
  biu_size_t if_size, dm_size, biu_size;
  biu_prot_t if_prot, dm_prot, biu_prot;
  logic if_ack, if_d_ack, dm_ack, dm_d_ack;
  logic biu_req, biu_lock, biu_we, biu_ack, biu_d_ack;
  logic [XLEN-1:0] biu_adr, biu_d, biu_q;
  arb_owner_t owner;
  logic [6:0] ctl;
  int checks = 0, errors = 0;
  int m_own, m_pend, m_last;
  bit m_lock;

  always #5 clk = ~clk;
  assign ctl = {biu_req, if_ack, dm_ack, if_d_ack, dm_d_ack, owner};

  riscv_biu_arbiter #(.XLEN(XLEN), .MAX_PEND(MAXP)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_req_i(if_req), .if_adr_i(if_adr), .if_size_i(if_size), .if_lock_i(if_lock),
    .if_prot_i(if_prot), .if_we_i(if_we), .if_d_i(if_d),
    .if_ack_o(if_ack), .if_d_ack_o(if_d_ack), .if_q_o(if_q),
    .dm_req_i(dm_req), .dm_adr_i(dm_adr), .dm_size_i(dm_size), .dm_lock_i(dm_lock),
    .dm_prot_i(dm_prot), .dm_we_i(dm_we), .dm_d_i(dm_d),
    .dm_ack_o(dm_ack), .dm_d_ack_o(dm_d_ack), .dm_q_o(dm_q),
    .biu_req_o(biu_req), .biu_adr_o(biu_adr), .biu_size_o(biu_size), .biu_lock_o(biu_lock),
    .biu_prot_o(biu_prot), .biu_we_o(biu_we), .biu_d_o(biu_d),
    .biu_ack_i(biu_ack), .biu_d_ack_i(biu_d_ack), .biu_q_i(biu_q),
    .owner_o(owner)
  );

  task automatic clear_inputs;
    flush = 0; if_req = 0; dm_req = 0; if_lock = 0; dm_lock = 0; if_we = 0; dm_we = 0;
    if_adr = '0; dm_adr = '0; if_d = '0; dm_d = '0; if_size = WORD; dm_size = WORD;
    if_prot = '0; dm_prot = '0; biu_ack = 0; biu_d_ack = 0; biu_q = '0;
  endtask

  task automatic reset_dut;
    rst = 1; clear_inputs();
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; clear_inputs(); if_req = 1; dm_req = 1; biu_ack = 1; biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL rst_hold got %b exp %b", ctl, 7'b0000000); end
    @(negedge clk); rst = 0; if_req = 0; biu_d_ack = 0;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL rst_c1 got %b exp %b", ctl, 7'b1010000); end
    @(negedge clk);
    #1 checks++; if (ctl !== 7'b1010010) begin errors++; $display("FAIL rst_c2 got %b exp %b", ctl, 7'b1010010); end
    @(negedge clk);
    #1 checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL rst_full got %b exp %b", ctl, 7'b0000010); end
    #2 rst = 1;
    #1 checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL rst_async got %b exp %b", ctl, 7'b0000000); end
    @(negedge clk); rst = 0; dm_req = 0; biu_ack = 0; biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL rst_late_dack got %b exp %b", ctl, 7'b0000000); end
    @(negedge clk); biu_d_ack = 0; dm_req = 1; biu_ack = 1;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL rst_pend_zero got %b exp %b", ctl, 7'b1010000); end
  endtask

  task automatic test_if_only;
    reset_dut();
    if_req = 1; if_adr = 32'h100; biu_ack = 1;
    #1 checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL if_grant got %b exp %b", ctl, 7'b1100000); end
    checks++; if (biu_adr !== 32'h100) begin errors++; $display("FAIL if_adr got %h exp %h", biu_adr, 32'h100); end
    @(negedge clk); if_req = 0; biu_ack = 0;
    #1 checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL if_owner got %b exp %b", ctl, 7'b0000001); end
    biu_d_ack = 1; biu_q = 32'hDEADBEEF;
    #1 checks++; if (ctl !== 7'b0001001) begin errors++; $display("FAIL if_dack got %b exp %b", ctl, 7'b0001001); end
    checks++; if (if_q !== 32'hDEADBEEF) begin errors++; $display("FAIL if_q got %h exp %h", if_q, 32'hDEADBEEF); end
    @(negedge clk); biu_d_ack = 0;
    #1 checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL if_release got %b exp %b", ctl, 7'b0000000); end
  endtask

  task automatic test_priority;
    logic [6:0] exp_tie;
    reset_dut();
    if_req = 1; dm_req = 1; biu_ack = 1; if_adr = 32'h100; dm_adr = 32'h200;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL prio_both got %b exp %b", ctl, 7'b1010000); end
    checks++; if (biu_adr !== 32'h200) begin errors++; $display("FAIL prio_adr got %h exp %h", biu_adr, 32'h200); end
    @(negedge clk); dm_req = 0;
    #1 checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL prio_if_blocked got %b exp %b", ctl, 7'b0000010); end
    biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL prio_dm_dack got %b exp %b", ctl, 7'b0000110); end
    @(negedge clk); biu_d_ack = 0;
    #1 checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL prio_if_after got %b exp %b", ctl, 7'b1100000); end
    @(negedge clk); if_req = 0; biu_ack = 0;
    #1 checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL prio_if_owner got %b exp %b", ctl, 7'b0000001); end
    biu_d_ack = 1;
    @(negedge clk); biu_d_ack = 0; dm_req = 1; biu_ack = 1;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL prio_dm_only got %b exp %b", ctl, 7'b1010000); end
    @(negedge clk); dm_req = 0; biu_ack = 0; biu_d_ack = 1;
    @(negedge clk); biu_d_ack = 0; if_req = 1; dm_req = 1; biu_ack = 1;
`ifdef RISCV_BIU_ARB_RR_EN
    exp_tie = 7'b1100000;
`else
    exp_tie = 7'b1010000;
`endif
    #1 checks++; if (ctl !== exp_tie) begin errors++; $display("FAIL prio_tie_after_dm got %b exp %b", ctl, exp_tie); end
  endtask

  task automatic test_max_pend;
    reset_dut();
    dm_req = 1; biu_ack = 1;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL mp_c1 got %b exp %b", ctl, 7'b1010000); end
    @(negedge clk);
    #1 checks++; if (ctl !== 7'b1010010) begin errors++; $display("FAIL mp_c2 got %b exp %b", ctl, 7'b1010010); end
    @(negedge clk);
    #1 checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL mp_full got %b exp %b", ctl, 7'b0000010); end
    biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL mp_full_dack got %b exp %b", ctl, 7'b0000110); end
    @(negedge clk); biu_d_ack = 0;
    #1 checks++; if (ctl !== 7'b1010010) begin errors++; $display("FAIL mp_reopen got %b exp %b", ctl, 7'b1010010); end
  endtask

  task automatic test_lock;
    reset_dut();
    if_req = 1; dm_req = 1; dm_lock = 1; biu_ack = 1;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL lk_c1 got %b exp %b", ctl, 7'b1010000); end
    @(negedge clk); biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b1010110) begin errors++; $display("FAIL lk_c2 got %b exp %b", ctl, 7'b1010110); end
    @(negedge clk); dm_req = 0;
    #1 checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL lk_c3 got %b exp %b", ctl, 7'b0000110); end
    @(negedge clk); biu_d_ack = 0; dm_req = 1; dm_lock = 0;
    #1 checks++; if (ctl !== 7'b1010010) begin errors++; $display("FAIL lk_held got %b exp %b", ctl, 7'b1010010); end
    @(negedge clk); dm_req = 0; biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL lk_last_dack got %b exp %b", ctl, 7'b0000110); end
    @(negedge clk); biu_d_ack = 0;
    #1 checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL lk_if_grant got %b exp %b", ctl, 7'b1100000); end
  endtask

  task automatic test_flush;
    reset_dut();
    if_req = 1; dm_req = 1; dm_lock = 1; biu_ack = 1;
    #1 checks++; if (ctl !== 7'b1010000) begin errors++; $display("FAIL fl_c1 got %b exp %b", ctl, 7'b1010000); end
    @(negedge clk); flush = 1;
    #1 checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL fl_block got %b exp %b", ctl, 7'b0000010); end
    @(negedge clk); flush = 0; dm_req = 0; biu_d_ack = 1;
    #1 checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL fl_dack got %b exp %b", ctl, 7'b0000110); end
    @(negedge clk); biu_d_ack = 0;
    #1 checks++; if (ctl !== 7'b1100000) begin errors++; $display("FAIL fl_if_grant got %b exp %b", ctl, 7'b1100000); end
    @(negedge clk); if_req = 0; biu_ack = 0;
    #1 checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL fl_if_owner got %b exp %b", ctl, 7'b0000001); end
  endtask

  task automatic model_reset;
    m_own = 0; m_pend = 0; m_lock = 0; m_last = 1;
  endtask

  task automatic test_random;
    int sel, sreq, acc, dec, npend, own_r, oth_r;
    bit nlock;
    logic [6:0] e_ctl;
    logic [2*XLEN+8:0] e_bus;
    reset_dut();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if_req = ($urandom_range(0, 2) != 0); dm_req = ($urandom_range(0, 2) != 0);
      if_lock = ($urandom_range(0, 3) == 0); dm_lock = ($urandom_range(0, 2) == 0);
      if_we = 1'($urandom); dm_we = 1'($urandom);
      if_adr = $urandom; dm_adr = $urandom; if_d = $urandom; dm_d = $urandom; biu_q = $urandom;
      if_size = biu_size_t'($urandom_range(0, 4)); dm_size = biu_size_t'($urandom_range(0, 4));
      if_prot = 3'($urandom); dm_prot = 3'($urandom);
      biu_ack = 1'($urandom);
      biu_d_ack = (m_pend > 0) && ($urandom_range(0, 1) == 1);
      if (rst) model_reset();
      #1;
      if (m_own != 0) sel = m_own;
`ifdef RISCV_BIU_ARB_RR_EN
      else if (if_req && dm_req) sel = (m_last == 1) ? 2 : 1;
`else
      else if (if_req && dm_req) sel = 2;
`endif
      else sel = dm_req ? 2 : if_req ? 1 : 0;
      sreq = (sel == 1) ? int'(if_req) : (sel == 2) ? int'(dm_req) : 0;
      sreq = (sreq != 0 && m_pend < MAXP && !flush && !rst) ? 1 : 0;
      acc = (sreq != 0 && biu_ack) ? 1 : 0;
      e_ctl = {sreq != 0, acc != 0 && sel == 1, acc != 0 && sel == 2,
               biu_d_ack && m_own == 1, biu_d_ack && m_own == 2, 2'(m_own)};
      checks++; if (ctl !== e_ctl) begin errors++; $display("FAIL rnd_ctl cyc %0d got %b exp %b", n, ctl, e_ctl); end
      checks++; if ({if_q, dm_q} !== {biu_q, biu_q}) begin errors++; $display("FAIL rnd_q cyc %0d got %h/%h exp %h", n, if_q, dm_q, biu_q); end
      if (sreq != 0) begin
        e_bus = (sel == 2) ? {dm_adr, dm_d, dm_we, dm_lock, dm_size, dm_prot} : {if_adr, if_d, if_we, if_lock, if_size, if_prot};
        checks++;
        if ({biu_adr, biu_d, biu_we, biu_lock, biu_size, biu_prot} !== e_bus) begin
          errors++; $display("FAIL rnd_bus cyc %0d got %h exp %h", n, {biu_adr, biu_d, biu_we, biu_lock, biu_size, biu_prot}, e_bus);
        end
      end
      if (!rst) begin
        dec = (biu_d_ack && m_pend > 0) ? 1 : 0;
        npend = m_pend + acc - dec;
        nlock = flush ? 1'b0 : (acc != 0) ? ((sel == 2) ? dm_lock : if_lock) : m_lock;
        if (m_own == 0) begin
          if (acc != 0) begin m_own = sel; m_last = sel; end
        end else begin
          own_r = (m_own == 1) ? int'(if_req) : int'(dm_req);
          oth_r = (m_own == 1) ? int'(dm_req) : int'(if_req);
          if (npend == 0 && !nlock && (own_r == 0 || oth_r != 0)) m_own = 0;
        end
        m_pend = npend; m_lock = nlock;
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_priority();
    test_max_pend();
    test_lock();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_biu_arbiter.md
Name: riscv_biu_arbiter

Overview:
- Shares one BIU request port between two requesters: instruction fetch (IF) and the data memory access buffer (DM).
- Both requesters present the same request bundle: req, adr, size, lock, prot, we, d.
- Sits between the instruction-side buffer, riscv_membuf and the BIU.
- Sequences ownership with a small FSM, tracks outstanding transfers, honours locked (atomic) sequences, and routes responses back to the owner.

Parameters:
- XLEN, 32, address/data width.
- MAX_PEND, 2, maximum accepted-but-unanswered transfers; counter width is $clog2(MAX_PEND)+1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  abandon lock hold; block new requests until pending drains.
- if_req_i, dm_req_i  in  1  request.
- if_adr_i, dm_adr_i  in  XLEN  address.
- if_size_i, dm_size_i  in  biu_size_t  transfer size.
- if_lock_i, dm_lock_i  in  1  locked sequence.
- if_prot_i, dm_prot_i  in  biu_prot_t  protection.
- if_we_i, dm_we_i  in  1  write enable.
- if_d_i, dm_d_i  in  XLEN  write data.
- if_ack_o, dm_ack_o  out  1  request accepted.
- if_d_ack_o, dm_d_ack_o  out  1  response valid.
- if_q_o, dm_q_o  out  XLEN  response data (copy of biu_q_i).
- biu_req_o  out  1  request to BIU.
- biu_adr_o, biu_size_o, biu_lock_o, biu_prot_o, biu_we_o, biu_d_o  out  per field  muxed request bundle.
- biu_ack_i  in  1  BIU accepted request (same cycle).
- biu_d_ack_i  in  1  BIU response valid.
- biu_q_i  in  XLEN  BIU read data.
- owner_o  out  2  current owner: 00 none, 01 IF, 10 DM.

Behaviour:
- FSM states: IDLE, OWN_IF, OWN_DM.
  - Reset: state IDLE, pending=0, lock_q=0, last_grant=IF.
  - While rst_i is high: biu_req_o=0, all *_ack_o=0, all *_d_ack_o=0, owner_o=00.
- Arbitration in IDLE is combinational, with no bubble:
  - Only one requester active: it is selected.
  - Both active: DM wins (fixed priority).
  - The selected bundle drives biu_*_o in the same cycle.
  - On biu_req_o & biu_ack_i, the state moves to OWN_<sel> at the next edge.
- In OWN_x, only x's bundle is forwarded. The other requester sees ack=0.
- Gating of biu_req_o: biu_req_o = sel_req & (pending<MAX_PEND) & ~flush_i.
  - x_ack_o = biu_ack_i & biu_req_o & grant_x.
- Pending counter:
  - +1 on accepted request.
  - -1 on biu_d_ack_i.
  - Both in the same cycle: unchanged.
  - biu_d_ack_i with pending==0: ignored, and the counter holds at 0.
- Response routing:
  - x_d_ack_o = biu_d_ack_i & (owner==x).
  - The owner cannot change while pending>0, so responses are in order.
  - Both *_q_o always equal biu_q_i.
- lock_q:
  - Set on an accepted request with lock=1.
  - Cleared on an accepted request with lock=0, or on flush_i.
- Release OWN_x -> IDLE at the edge where all of these hold:
  - pending_next==0,
  - lock_q_next==0,
  - and (~x_req_i or other_req_i).
- The release costs one IDLE cycle before any re-grant. Ownership never changes mid-lock.
- flush_i effects:
  - biu_req_o is forced to 0 that cycle.
  - lock_q is cleared.
  - The pending count still drains via biu_d_ack_i, and the FSM releases normally.
- Reset asserted mid-transfer: everything returns to reset values immediately. Late biu_d_ack_i is then dropped because pending=0.
- last_grant updates on every IDLE->OWN_x transition.

Optional Feature:
- Macro: RISCV_BIU_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are active in IDLE, the one not equal to last_grant wins. The forced release when the other requester is waiting is kept.
- Undefined: fixed DM priority. last_grant is still maintained but unused.

Decomposition:
- biu_constants_pkg: existing biu_size_t and biu_prot_t.
- New arb_owner_t enum {ARB_IDLE, ARB_IF, ARB_DM} added to the same package, so owner_o is typed consistently with the BIU.
- One sub-module: riscv_biu_arb_cnt, a saturating up/down pending counter with inc, dec, clr, full and zero outputs.

Test Plan:
- Reset with rst_i=1 pulsed mid-stream, pending=2 -> biu_req_o=0 and owner_o=00 immediately; a subsequent biu_d_ack_i produces no *_d_ack_o.
- IF only, adr 0x100, biu_ack_i same cycle -> if_ack_o=1 that cycle, owner_o=01 next cycle; biu_d_ack_i with q=0xDEADBEEF -> if_d_ack_o=1, if_q_o=0xDEADBEEF.
- IF and DM both requesting in IDLE, fixed priority -> dm_ack_o first. After DM response: one IDLE cycle, then IF granted. With RR_EN and last_grant=DM -> IF granted first.
- MAX_PEND=2, BIU acks 2 DM requests with no responses -> biu_req_o=0 on the third cycle; one biu_d_ack_i -> biu_req_o=1 the next cycle.
- DM lock sequence (lock=1, lock=1, lock=0) with IF requesting throughout -> IF is never granted until after the lock=0 transfer is acked and pending reaches 0.
- flush_i during DM lock with pending=1 -> biu_req_o=0 that cycle, lock_q=0; after biu_d_ack_i, release to IDLE and grant IF.
